chacha20_block_engine: RTL and testbench

Iterative ChaCha20 block-function engine (RFC 8439) producing one 512-bit keystream block per request.
Sits directly upstream of the 2-bit ready-status PIO input: its status[1:0] output drives that PIO's in_port, so software polls readiness over Avalon.
start and ack come from PIO output registers; key, nonce and counter come from register-backed PIO outputs.
Computes one quarter-round per clock.

---
 rtl/chacha20_pkg.sv | 62 ++++++
 rtl/chacha20_qr.sv | 29 ++
 rtl/chacha20_block_engine.sv | 191 +++++++++++++++++++
 tb/tb_chacha20_block_engine.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/chacha20_pkg.sv
// Shared definitions for the ChaCha20 block engine: sigma constants, FSM
// state encoding, quarter-round operand table and small helpers.
package chacha20_pkg;

  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] SIGMA0 = 32'h61707865;
  localparam logic [WORD_W-1:0] SIGMA1 = 32'h3320646e;
  localparam logic [WORD_W-1:0] SIGMA2 = 32'h79622d32;
  localparam logic [WORD_W-1:0] SIGMA3 = 32'h6b206574;

  // LOAD is folded into the IDLE accept edge but keeps its encoding slot.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  typedef logic [3:0] widx_t;

  typedef struct packed {
    widx_t a;
    widx_t b;
    widx_t c;
    widx_t d;
  } qr_sel_t;

  // Quarter-round operand table: entries 0-3 columns, 4-7 diagonals.
  function automatic qr_sel_t qr_table(input logic [2:0] idx);
    qr_sel_t sel;
    case (idx)
      3'd0:    sel = '{a: 4'd0, b: 4'd4, c: 4'd8,  d: 4'd12};
      3'd1:    sel = '{a: 4'd1, b: 4'd5, c: 4'd9,  d: 4'd13};
      3'd2:    sel = '{a: 4'd2, b: 4'd6, c: 4'd10, d: 4'd14};
      3'd3:    sel = '{a: 4'd3, b: 4'd7, c: 4'd11, d: 4'd15};
      3'd4:    sel = '{a: 4'd0, b: 4'd5, c: 4'd10, d: 4'd15};
      3'd5:    sel = '{a: 4'd1, b: 4'd6, c: 4'd11, d: 4'd12};
      3'd6:    sel = '{a: 4'd2, b: 4'd7, c: 4'd8,  d: 4'd13};
      3'd7:    sel = '{a: 4'd3, b: 4'd4, c: 4'd9,  d: 4'd14};
      default: sel = '{a: 4'd0, b: 4'd4, c: 4'd8,  d: 4'd12};
    endcase
    return sel;
  endfunction

  // Status word seen by software: bit0 ready (IDLE), bit1 block valid (DONE).
  function automatic logic [1:0] status_of(input state_e st);
    logic [1:0] s;
    case (st)
      ST_IDLE: s = 2'b01;
      ST_DONE: s = 2'b10;
      default: s = 2'b00;
    endcase
    return s;
  endfunction

  function automatic logic [WORD_W-1:0] rotl32(input logic [WORD_W-1:0] x, input int n);
    return (x << n) | (x >> (WORD_W - n));
  endfunction

endpackage

// File: rtl/chacha20_qr.sv
// ChaCha20 quarter-round, purely combinational; all adds are mod 2^32.
module chacha20_qr
  import chacha20_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic [WORD_W-1:0] c,
  input  logic [WORD_W-1:0] d,
  output logic [WORD_W-1:0] a_new,
  output logic [WORD_W-1:0] b_new,
  output logic [WORD_W-1:0] c_new,
  output logic [WORD_W-1:0] d_new
);

  logic [WORD_W-1:0] a1_s, b1_s, c1_s, d1_s;

  // Two add/xor/rotate half-steps, rotations 16/12 then 8/7.
  always_comb begin
    a1_s  = a + b;
    d1_s  = rotl32(d ^ a1_s, 16);
    c1_s  = c + d1_s;
    b1_s  = rotl32(b ^ c1_s, 12);
    a_new = a1_s + b1_s;
    d_new = rotl32(d1_s ^ a_new, 8);
    c_new = c1_s + d_new;
    b_new = rotl32(b1_s ^ c_new, 7);
  end

endmodule

// File: rtl/chacha20_block_engine.sv
// Iterative ChaCha20 block engine: one quarter-round per clock, one 512-bit
// keystream block per request, status[1:0] polled by software.
// Optional build macro CHACHA20_ZEROIZE_EN: clear keystream and all state
// registers on the acknowledge edge so no key material lingers.
module chacha20_block_engine
  import chacha20_pkg::*;
#(
  parameter int ROUNDS = 20
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         ack,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  counter,
  output logic [511:0] keystream,
  output logic [1:0]   status
);

  localparam logic [7:0] DR_LAST = 8'(ROUNDS / 2 - 1);

  state_e            state_r;
  state_e            state_next_s;
  logic [WORD_W-1:0] work_r [16];
  logic [WORD_W-1:0] orig_r [16];
  logic [WORD_W-1:0] init_s [16];
  logic [2:0]        qr_idx_r;
  logic [7:0]        round_cnt_r;
  logic [511:0]      keystream_r;
  logic [1:0]        status_r;
  logic              last_qr_s;

  qr_sel_t           sel_s;
  logic [WORD_W-1:0] qa_s, qb_s, qc_s, qd_s;
  logic [WORD_W-1:0] qa_new_s, qb_new_s, qc_new_s, qd_new_s;

  assign keystream = keystream_r;
  assign status    = status_r;

  // Initial state image: sigma, key words 4-11, counter 12, nonce 13-15.
  always_comb begin
    init_s[0] = SIGMA0;
    init_s[1] = SIGMA1;
    init_s[2] = SIGMA2;
    init_s[3] = SIGMA3;
    for (int i = 0; i < 8; i++) begin
      init_s[4+i] = key[WORD_W*i +: WORD_W];
    end
    init_s[12] = counter;
    for (int i = 0; i < 3; i++) begin
      init_s[13+i] = nonce[WORD_W*i +: WORD_W];
    end
  end

  // Operand mux: pick the four words addressed by the current qr_idx.
  always_comb begin
    sel_s     = qr_table(qr_idx_r);
    qa_s      = work_r[sel_s.a];
    qb_s      = work_r[sel_s.b];
    qc_s      = work_r[sel_s.c];
    qd_s      = work_r[sel_s.d];
    last_qr_s = (qr_idx_r == 3'd7) && (round_cnt_r == DR_LAST);
  end

  chacha20_qr u_qr (
    .a     (qa_s),
    .b     (qb_s),
    .c     (qc_s),
    .d     (qd_s),
    .a_new (qa_new_s),
    .b_new (qb_new_s),
    .c_new (qc_new_s),
    .d_new (qd_new_s)
  );

  // Next-state logic; ack has priority in DONE, start/ack ignored while busy.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_next_s = ST_ROUND;
        else       state_next_s = ST_IDLE;
      end
      ST_LOAD:  state_next_s = ST_ROUND;
      ST_ROUND: begin
        if (last_qr_s) state_next_s = ST_FINAL;
        else           state_next_s = ST_ROUND;
      end
      ST_FINAL: state_next_s = ST_DONE;
      ST_DONE: begin
        if (ack) state_next_s = ST_IDLE;
        else     state_next_s = ST_DONE;
      end
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // State register plus registered status decode of the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      status_r <= 2'b01;
    end else begin
      state_r  <= state_next_s;
      status_r <= status_of(state_next_s);
    end
  end

  // Quarter-round position and double-round counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      qr_idx_r    <= 3'd0;
      round_cnt_r <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            qr_idx_r    <= 3'd0;
            round_cnt_r <= 8'd0;
          end
        end
        ST_ROUND: begin
          qr_idx_r <= qr_idx_r + 3'd1;
          if (qr_idx_r == 3'd7) round_cnt_r <= round_cnt_r + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Working and original state: load on accept, one quarter-round per ROUND cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        work_r[i] <= 32'h0;
        orig_r[i] <= 32'h0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            for (int i = 0; i < 16; i++) begin
              work_r[i] <= init_s[i];
              orig_r[i] <= init_s[i];
            end
          end
        end
        ST_ROUND: begin
          work_r[sel_s.a] <= qa_new_s;
          work_r[sel_s.b] <= qb_new_s;
          work_r[sel_s.c] <= qc_new_s;
          work_r[sel_s.d] <= qd_new_s;
        end
`ifdef CHACHA20_ZEROIZE_EN
        ST_DONE: begin
          if (ack) begin
            for (int i = 0; i < 16; i++) begin
              work_r[i] <= 32'h0;
              orig_r[i] <= 32'h0;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  // Keystream: feed-forward add in FINAL, held through DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      keystream_r <= 512'h0;
    end else begin
      case (state_r)
        ST_FINAL: begin
          for (int i = 0; i < 16; i++) begin
            keystream_r[WORD_W*i +: WORD_W] <= work_r[i] + orig_r[i];
          end
        end
`ifdef CHACHA20_ZEROIZE_EN
        ST_DONE: begin
          if (ack) keystream_r <= 512'h0;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha20_block_engine.sv
// Scoreboard bench for chacha20_block_engine: stimulus pushes expected
// blocks, a negedge monitor pops and checks when the engine enters DONE.
module tb_chacha20_block_engine;

  logic         clk;
  logic         reset_n;
  logic         start;
  logic         ack;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  counter;
  logic [511:0] keystream;
  logic [1:0]   status;

  logic [31:0]  qa, qb, qc, qd, qa_n, qb_n, qc_n, qd_n;

  typedef struct {
    logic [127:0] words;
    bit           exact;
    int           start_edge;
  } sb_item_t;

  sb_item_t     sb_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  int           cyc = 0;
  logic [1:0]   prev_status = 2'b01;
  logic [511:0] saved_ks;

  localparam logic [127:0] RFC_W0_3 = {32'hc47120a3, 32'h1fdd0f50, 32'h15593bd1, 32'he4e7f110};
  localparam logic [255:0] RFC_KEY  = {32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
                                       32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100};
  localparam logic [95:0]  RFC_NONCE = {32'h00000000, 32'h4a000000, 32'h09000000};

  chacha20_block_engine #(.ROUNDS(20)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .ack       (ack),
    .key       (key),
    .nonce     (nonce),
    .counter   (counter),
    .keystream (keystream),
    .status    (status)
  );

  chacha20_qr u_qr_tb (
    .a (qa), .b (qb), .c (qc), .d (qd),
    .a_new (qa_n), .b_new (qb_n), .c_new (qc_n), .d_new (qd_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_ne(input string name, input logic [511:0] act, input logic [511:0] other);
    n_cmp++;
    if (act === other) begin
      n_bad++;
      $display("FAIL %s: got %h, must differ from %h", name, act, other);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [127:0] w, input bit exact, input int edge_no);
    sb_item_t it;
    it.words = w;
    it.exact = exact;
    it.start_edge = edge_no;
    sb_q.push_back(it);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (status !== 2'b10 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (status !== 2'b10) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_done: status %b after %0d cycles", status, n);
    end
  endtask

  // Monitor: on entry to DONE pop the oldest expectation and compare.
  always @(negedge clk) begin
    sb_item_t it;
    if (reset_n && status == 2'b10 && prev_status != 2'b10) begin
      if (sb_q.size() == 0) begin
        chk_int("unexpected_done", 1, 0);
      end else begin
        it = sb_q.pop_front();
        chk_int("latency", cyc - it.start_edge, 81);
        if (it.exact) chk("block_w0_3", {384'h0, keystream[127:0]}, {384'h0, it.words});
        else          chk_ne("block_differs", {384'h0, keystream[127:0]}, {384'h0, it.words});
      end
    end
    prev_status <= status;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    ack     = 1'b0;
    key     = RFC_KEY;
    nonce   = RFC_NONCE;
    counter = 32'd1;

    // Standalone quarter-round vector
    qa = 32'h11111111; qb = 32'h01020304; qc = 32'h9b8d6f43; qd = 32'h01234567;
    #1;
    chk("qr_a", {480'h0, qa_n}, {480'h0, 32'hea2a92f4});
    chk("qr_b", {480'h0, qb_n}, {480'h0, 32'hcb1cf8ce});
    chk("qr_c", {480'h0, qc_n}, {480'h0, 32'h4581472e});
    chk("qr_d", {480'h0, qd_n}, {480'h0, 32'h5881c4bb});

    repeat (3) @(negedge clk);
    chk("rst_status", {510'h0, status}, {510'h0, 2'b01});
    chk("rst_keystream", keystream, 512'h0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_status", {510'h0, status}, {510'h0, 2'b01});

    // Block A: RFC vector, inputs disturbed after the accept edge
    start = 1'b1;
    push(RFC_W0_3, 1'b1, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    counter = 32'hdeadbeef;
    key = ~RFC_KEY;
    chk("busy_status", {510'h0, status}, {510'h0, 2'b00});
    wait_done(100);
    saved_ks = keystream;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("done_hold_status", {510'h0, status}, {510'h0, 2'b10});
      chk("done_hold_ks", keystream, saved_ks);
    end
    start = 1'b0;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("ack_status", {510'h0, status}, {510'h0, 2'b01});
`ifdef CHACHA20_ZEROIZE_EN
    chk("ack_ks_zeroized", keystream, 512'h0);
`else
    chk("ack_ks_kept", keystream, saved_ks);
`endif

    // Block B: counter 2 must give a different block
    key = RFC_KEY;
    counter = 32'd2;
    start = 1'b1;
    push(RFC_W0_3, 1'b0, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    wait_done(100);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("ack2_status", {510'h0, status}, {510'h0, 2'b01});

    // Block C: asynchronous reset 40 cycles into ROUND, then a clean block
    counter = 32'd1;
    start = 1'b1;
    push(RFC_W0_3, 1'b1, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    repeat (39) @(negedge clk);
    chk("mid_round_status", {510'h0, status}, {510'h0, 2'b00});
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_status", {510'h0, status}, {510'h0, 2'b01});
    chk("async_rst_ks", keystream, 512'h0);
    sb_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    push(RFC_W0_3, 1'b1, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    wait_done(100);

    // Block D: start and ack together in DONE, start kept high
    start = 1'b1;
    ack = 1'b1;
    push(RFC_W0_3, 1'b1, cyc + 2);
    @(negedge clk);
    ack = 1'b0;
    chk("start_ack_status", {510'h0, status}, {510'h0, 2'b01});
    @(negedge clk);
    start = 1'b0;
    chk("restart_status", {510'h0, status}, {510'h0, 2'b00});
    wait_done(100);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    repeat (3) @(negedge clk);
    chk_int("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
